// File: rtl/div_seq.sv
// div_seq: multi-cycle non-restoring integer divider, one quotient bit per clock.
// Handles signed and unsigned operands, flags divide-by-zero, and holds its results
// stable until the next operation completes.
module div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } state_e;

  state_e           state_q;
  logic [WIDTH:0]   rem_q;      // signed partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH:0]   dvs_q;      // |divisor|
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_mag;

  // Operand signs and magnitudes presented at capture time.
  always_comb begin
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    // |MIN| = 2^(WIDTH-1) is still exact as an unsigned WIDTH-bit value.
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -{1'b1, divisor} : {1'b0, divisor};
  end

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] rem_pos;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // One non-restoring step, plus the final restore and sign application.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    // Wrap-around in WIDTH+1 bits is harmless: the true step result always fits.
    rem_step  = rem_q[WIDTH] ? rem_shift + dvs_q : rem_shift - dvs_q;
    rem_pos   = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_pos : rem_pos;
  end

  // Control FSM with all datapath state and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            rem_q     <= '0;
            dvs_q     <= dvs_mag;
            cnt_q     <= CNT_W'(WIDTH);
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            if (divisor == '0) begin
              // Keep the raw dividend: it is reported unmodified as the remainder.
              zero_q  <= 1'b1;
              quo_q   <= dividend;
              state_q <= StFix;
            end else begin
              zero_q  <= 1'b0;
              quo_q   <= dvd_mag;
              state_q <= StIter;
            end
          end
        end
        StIter: begin
          rem_q <= rem_step;
          quo_q <= {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (zero_q) begin
            quotient    <= '1;
            remainder   <= quo_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= quo_fix;
            remainder   <= rem_fix;
            div_by_zero <= 1'b0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized vectors on a 32-bit
// and an 8-bit instance, compared against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        clr;

  logic        start32, sop32, busy32, done32, dbz32;
  logic [31:0] a32, b32, q32, r32;
  logic        start8, sop8, busy8, done8, dbz8;
  logic [7:0]  a8, b8, q8, r8;

  int n_checks = 0;
  int n_errors = 0;

  // Last expected result per instance (index 0: 32-bit, 1: 8-bit), for hold checks.
  logic [31:0] prev_q [2];
  logic        prev_z [2];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .clr        (clr),
    .start      (start32),
    .signed_op  (sop32),
    .dividend   (a32),
    .divisor    (b32),
    .busy       (busy32),
    .done       (done32),
    .div_by_zero(dbz32),
    .quotient   (q32),
    .remainder  (r32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .clr        (clr),
    .start      (start8),
    .signed_op  (sop8),
    .dividend   (a8),
    .divisor    (b8),
    .busy       (busy8),
    .done       (done8),
    .div_by_zero(dbz8),
    .quotient   (q8),
    .remainder  (r8)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with C-style truncation, remainder follows dividend.
  function automatic void ref_div(input int w, input bit sop, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic z);
    longint sa, sb, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a);
    sb = longint'(b);
    if (b == 0) begin
      q = 32'(mask);
      r = a;
      z = 1'b1;
    end else begin
      if (sop && a[w-1]) sa = sa - (longint'(1) << w);
      if (sop && b[w-1]) sb = sb - (longint'(1) << w);
      q = 32'((sa / sb) & mask);
      r = 32'((sa % sb) & mask);
      z = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand(input int w);
    logic [31:0] mask, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = 32'($urandom_range(1, 15));
      2:       v = mask;
      3:       v = 32'(1) << (w - 1);
      default: v = $urandom & mask;
    endcase
    return v;
  endfunction

  // Issue one divide and wait (bounded) for done; operand inputs are scrambled while busy
  // and an extra start can be injected after a given number of edges.
  task automatic do_div(input bit w8, input bit sop, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output logic [31:0] q, output logic [31:0] r,
                        output logic z, output int edges, output int busy_cyc,
                        output logic [31:0] q_cap, output logic z_cap, output logic busy_end);
    if (w8) begin
      start8 = 1'b1; sop8 = sop; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; sop32 = sop; a32 = a; b32 = b;
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    start32 = 1'b0;
    q_cap = w8 ? {24'd0, q8} : q32;
    z_cap = w8 ? dbz8 : dbz32;
    edges = 0;
    busy_cyc = 0;
    while (!(w8 ? done8 : done32) && edges < 100) begin
      if (w8 ? busy8 : busy32) busy_cyc++;
      start8  = w8 && (edges == inject_at);
      start32 = !w8 && (edges == inject_at);
      sop8  = 1'($urandom);
      sop32 = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      @(posedge clk); #1;
      edges++;
    end
    start8 = 1'b0;
    start32 = 1'b0;
    q = w8 ? {24'd0, q8} : q32;
    r = w8 ? {24'd0, r8} : r32;
    z = w8 ? dbz8 : dbz32;
    busy_end = w8 ? busy8 : busy32;
  endtask

  task automatic run_check(input bit w8, input bit sop, input logic [31:0] a,
                           input logic [31:0] b, input int inject_at, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez, input string tag);
    logic [31:0] q, r, q_cap;
    logic        z, z_cap, busy_end;
    int          edges, busy_cyc, exp_edges, idx;
    do_div(w8, sop, a, b, inject_at, q, r, z, edges, busy_cyc, q_cap, z_cap, busy_end);
    idx = w8 ? 1 : 0;
    exp_edges = (b == 0) ? 1 : (w8 ? 9 : 33);
    check_val({tag, " quotient"}, q, eq);
    check_val({tag, " remainder"}, r, er);
    check_val({tag, " div_by_zero"}, z, ez);
    check_val({tag, " done latency"}, edges, exp_edges);
    check_val({tag, " busy cycles"}, busy_cyc, exp_edges);
    check_val({tag, " busy at done"}, busy_end, 0);
    check_val({tag, " quotient held at start"}, q_cap, prev_q[idx]);
    check_val({tag, " flag held at start"}, z_cap, prev_z[idx]);
    prev_q[idx] = eq;
    prev_z[idx] = ez;
  endtask

  task automatic run_random(input bit w8, input int n);
    logic [31:0] a, b, eq, er;
    logic        ez;
    bit          sop;
    int          w;
    w = w8 ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      a = pick_operand(w);
      b = pick_operand(w);
      sop = 1'($urandom);
      ref_div(w, sop, a, b, eq, er, ez);
      run_check(w8, sop, a, b, -1, eq, er, ez, $sformatf("rnd%0d[%0d] %0s %0h/%0h", w, i,
                sop ? "s" : "u", a, b));
    end
  endtask

  initial begin
    int seen_done;
    clr = 1'b0;
    start32 = 1'b0; sop32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sop8 = 1'b0; a8 = '0; b8 = '0;
    prev_q[0] = '0; prev_q[1] = '0;
    prev_z[0] = 1'b0; prev_z[1] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("reset busy32", busy32, 0);
    check_val("reset done32", done32, 0);
    check_val("reset dbz32", dbz32, 0);
    check_val("reset q32", q32, 0);
    check_val("reset r32", r32, 0);
    check_val("reset busy8", busy8, 0);
    check_val("reset done8", done8, 0);
    check_val("reset dbz8", dbz8, 0);
    check_val("reset q8", q8, 0);
    check_val("reset r8", r8, 0);
    #3 clr = 1'b1;
    @(posedge clk); #1;

    run_check(0, 0, 32'd100, 32'd7, -1, 32'd14, 32'd2, 0, "u 100/7");
    run_check(0, 1, 32'hFFFF_FF9C, 32'd7, -1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, "s -100/7");
    run_check(0, 1, 32'd100, 32'hFFFF_FFF9, -1, 32'hFFFF_FFF2, 32'd2, 0, "s 100/-7");
    run_check(0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, 32'd14, 32'hFFFF_FFFE, 0, "s -100/-7");
    run_check(0, 0, 32'hFFFF_FFFF, 32'd1, -1, 32'hFFFF_FFFF, 32'd0, 0, "u max/1");
    run_check(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000, 32'd0, 0, "s min/-1");
    run_check(0, 0, 32'h1234, 32'd0, -1, 32'hFFFF_FFFF, 32'h1234, 1, "u 0x1234/0");
    run_check(0, 0, 32'd9, 32'd3, -1, 32'd3, 32'd0, 0, "u 9/3 after div0");
    run_check(0, 1, 32'h8000_1234, 32'd0, -1, 32'hFFFF_FFFF, 32'h8000_1234, 1, "s neg/0");
    run_check(0, 0, 32'd50, 32'd5, 4, 32'd10, 32'd0, 0, "u 50/5 start while busy");

    // Done is a single-cycle pulse and results hold while idle.
    @(posedge clk); #1;
    check_val("done pulse width", done32, 0);
    check_val("quotient held idle", q32, 32'd10);

    // Reset in the middle of a divide aborts it.
    start32 = 1'b1; sop32 = 1'b0; a32 = 32'd123456; b32 = 32'd789;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    check_val("abort busy", busy32, 0);
    check_val("abort done", done32, 0);
    check_val("abort dbz", dbz32, 0);
    check_val("abort quotient", q32, 0);
    check_val("abort remainder", r32, 0);
    prev_q[0] = '0; prev_z[0] = 1'b0;
    prev_q[1] = '0; prev_z[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen_done++;
    end
    check_val("no activity after abort", seen_done, 0);
    run_check(0, 0, 32'd7, 32'd2, -1, 32'd3, 32'd1, 0, "u 7/2 after reset");

    run_check(1, 1, 32'h80, 32'hFF, -1, 32'h80, 32'h0, 0, "s8 min/-1");
    run_check(1, 1, 32'h85, 32'h0, -1, 32'hFF, 32'h85, 1, "s8 neg/0");
    run_check(1, 1, 32'h9C, 32'h07, -1, 32'hF2, 32'hFE, 0, "s8 -100/7");

    run_random(0, 1100);
    run_random(1, 2500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
